// File: rtl/video_timing_checker.sv
// Receive-side raster measurement: reports line/frame totals and active sizes,
// and declares lock once LOCK_FRAMES consecutive frames match the configured mode.
module video_timing_checker #(
    parameter int H_TOTAL     = 2200,
    parameter int V_TOTAL     = 1125,
    parameter int H_ACTIVE    = 1920,
    parameter int V_ACTIVE    = 1080,
    parameter int LOCK_FRAMES = 3,
    parameter int CNT_W       = 12,
    parameter int TIMEOUT_W   = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsyncIn,
    input  logic             vsyncIn,
    input  logic             deIn,
    output logic [CNT_W-1:0] hTotal,
    output logic [CNT_W-1:0] vTotal,
    output logic [CNT_W-1:0] hActive,
    output logic [CNT_W-1:0] vActive,
    output logic             measValid,
    output logic             frameStrobe,
    output logic             locked,
    output logic             lockLost
);

    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WD_MAX   = '1;
    localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(2 * H_TOTAL * V_TOTAL);

    typedef enum logic {SEARCH, LOCKED} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // bit 0 = hsync, bit 1 = vsync, bit 2 = de
    logic [2:0] s1_reg, s2_reg;
    logic       h_rise, v_rise, de_fall, de_s1;

    logic [CNT_W-1:0]     h_cnt_reg, line_len_reg, de_cnt_reg, line_act_reg;
    logic [CNT_W-1:0]     de_lines_reg, v_cnt_reg;
    logic [TIMEOUT_W-1:0] wd_cnt_reg;
    logic                 armed_reg;

    logic [CNT_W-1:0] h_total_reg, v_total_reg, h_active_reg, v_active_reg;
    logic             meas_valid_reg, frame_strobe_reg;

    logic [CNT_W-1:0] line_len_next, line_act_next, de_lines_cur;
    logic             strobe, timeout, match;

    state_t     state_reg, state_next;
    logic [3:0] match_cnt_reg, match_cnt_next;
    logic       lock_lost_reg, lock_lost_next;

    assign h_rise  = s1_reg[0] & ~s2_reg[0];
    assign v_rise  = s1_reg[1] & ~s2_reg[1];
    assign de_fall = ~s1_reg[2] & s2_reg[2];
    assign de_s1   = s1_reg[2];

    // Coincident edges are folded in so a frame boundary sees the line that just closed.
    assign line_len_next = h_rise  ? h_cnt_reg  : line_len_reg;
    assign line_act_next = de_fall ? de_cnt_reg : line_act_reg;
    assign de_lines_cur  = de_fall ? sat_inc(de_lines_reg) : de_lines_reg;

    assign strobe  = v_rise & armed_reg;
    assign timeout = ~v_rise & (wd_cnt_reg == WD_LIMIT);
    assign match   = (line_len_next == CNT_W'(H_TOTAL))  && (v_cnt_reg == CNT_W'(V_TOTAL)) &&
                     (line_act_next == CNT_W'(H_ACTIVE)) && (de_lines_cur == CNT_W'(V_ACTIVE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg           <= '0;
            s2_reg           <= '0;
            h_cnt_reg        <= '0;
            line_len_reg     <= '0;
            de_cnt_reg       <= '0;
            line_act_reg     <= '0;
            de_lines_reg     <= '0;
            v_cnt_reg        <= '0;
            wd_cnt_reg       <= '0;
            armed_reg        <= 1'b0;
            h_total_reg      <= '0;
            v_total_reg      <= '0;
            h_active_reg     <= '0;
            v_active_reg     <= '0;
            meas_valid_reg   <= 1'b0;
            frame_strobe_reg <= 1'b0;
        end else begin
            s1_reg <= {deIn, vsyncIn, hsyncIn};
            s2_reg <= s1_reg;

            h_cnt_reg    <= h_rise ? CNT_W'(1) : sat_inc(h_cnt_reg);
            line_len_reg <= line_len_next;

            if (de_fall)
                de_cnt_reg <= '0;
            else if (de_s1)
                de_cnt_reg <= sat_inc(de_cnt_reg);
            line_act_reg <= line_act_next;

            if (v_rise) begin
                // an hsync edge in the same cycle already belongs to the new frame
                v_cnt_reg    <= h_rise ? CNT_W'(1) : '0;
                de_lines_reg <= '0;
                wd_cnt_reg   <= '0;
                armed_reg    <= 1'b1;
            end else begin
                if (h_rise)
                    v_cnt_reg <= sat_inc(v_cnt_reg);
                de_lines_reg <= de_lines_cur;
                wd_cnt_reg   <= (wd_cnt_reg == WD_MAX) ? wd_cnt_reg : wd_cnt_reg + TIMEOUT_W'(1);
                if (timeout)
                    armed_reg <= 1'b0;
            end

            frame_strobe_reg <= strobe;
            if (strobe) begin
                h_total_reg    <= line_len_next;
                v_total_reg    <= v_cnt_reg;
                h_active_reg   <= line_act_next;
                v_active_reg   <= de_lines_cur;
                meas_valid_reg <= 1'b1;
            end else if (timeout) begin
                meas_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= SEARCH;
            match_cnt_reg <= '0;
            lock_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            match_cnt_reg <= match_cnt_next;
            lock_lost_reg <= lock_lost_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        lock_lost_next = 1'b0;
        if (timeout) begin
            state_next     = SEARCH;
            match_cnt_next = '0;
            lock_lost_next = (state_reg == LOCKED);
        end else if (strobe) begin
            case (state_reg)
                SEARCH: begin
                    if (!match) begin
                        match_cnt_next = '0;
                    end else if (match_cnt_reg == 4'(LOCK_FRAMES - 1)) begin
                        state_next     = LOCKED;
                        match_cnt_next = '0;
                    end else begin
                        match_cnt_next = match_cnt_reg + 4'd1;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        state_next     = SEARCH;
                        match_cnt_next = '0;
                        lock_lost_next = 1'b1;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    assign hTotal      = h_total_reg;
    assign vTotal      = v_total_reg;
    assign hActive     = h_active_reg;
    assign vActive     = v_active_reg;
    assign measValid   = meas_valid_reg;
    assign frameStrobe = frame_strobe_reg;
    assign locked      = (state_reg == LOCKED);
    assign lockLost    = lock_lost_reg;

endmodule

// File: tb/tb_video_timing_checker.sv
// Bench for video_timing_checker using a reduced 40x20 raster (32x16 active)
// so every scenario, including the frame watchdog, fits in a short run.
`timescale 1ns/1ps
module tb_video_timing_checker;

    localparam int HT = 40, VT = 20, HA = 32, VA = 16, LF = 3, CW = 12, TW = 12;
    localparam int WD_LIMIT = 2 * HT * VT;

    logic clk = 1'b0, rst = 1'b1, hs = 1'b0, vs = 1'b0, de = 1'b0;
    logic [CW-1:0] h_total, v_total, h_active, v_active;
    logic meas_valid, frame_strobe, locked, lock_lost;

    video_timing_checker #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .LOCK_FRAMES(LF), .CNT_W(CW), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .hsyncIn(hs), .vsyncIn(vs), .deIn(de),
        .hTotal(h_total), .vTotal(v_total), .hActive(h_active), .vActive(v_active),
        .measValid(meas_valid), .frameStrobe(frame_strobe),
        .locked(locked), .lockLost(lock_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] h, v, ha, va;
        logic lk, ll;
    } meas_t;

    meas_t exp_q[$], obs_q[$];
    meas_t exp_m, obs_m;
    int checks = 0, errors = 0;
    int cyc = 0, lost_cnt = 0, lost_cyc = 0, last_vrise_cyc = 0;
    bit tb_armed = 0, tb_locked = 0;
    int tb_mcnt = 0, prev_h = 0, prev_v = 0, prev_ha = 0, prev_va = 0;

    // One pixel per clock: sample outputs on the falling edge, then drive the next pixel.
    task automatic drive_pixel(input logic h_in, input logic v_in, input logic d_in);
        @(negedge clk);
        cyc++;
        if (frame_strobe) obs_q.push_back({h_total, v_total, h_active, v_active, locked, lock_lost});
        if (lock_lost) begin
            lost_cnt++;
            lost_cyc = cyc;
        end
        if (v_in && !vs) last_vrise_cyc = cyc;
        hs = h_in;
        vs = v_in;
        de = d_in;
    endtask

    // Expected report at a frame boundary describes the frame that just ended.
    task automatic model_vrise(input int h, input int v, input int ha, input int va);
        bit match, lost;
        if (tb_armed) begin
            match = (prev_h == HT) && (prev_v == VT) && (prev_ha == HA) && (prev_va == VA);
            lost = 0;
            if (tb_locked) begin
                if (!match) begin
                    tb_locked = 0;
                    lost = 1;
                    tb_mcnt = 0;
                end
            end else if (match) begin
                tb_mcnt++;
                if (tb_mcnt == LF) begin
                    tb_locked = 1;
                    tb_mcnt = 0;
                end
            end else begin
                tb_mcnt = 0;
            end
            exp_q.push_back({CW'(prev_h), CW'(prev_v), CW'(prev_ha), CW'(prev_va), tb_locked, lost});
        end
        tb_armed = 1;
        prev_h = h;
        prev_v = v;
        prev_ha = ha;
        prev_va = va;
    endtask

    task automatic send_frame(input int h, input int v, input int ha, input int va,
                              input int extra, input int voff, input bit vs_en, input int stop_after);
        int f, n, len, pos, rel;
        f = h * v;
        n = 0;
        if (vs_en) model_vrise((voff == 0) ? h + extra : h, v, ha, va);
        for (int y = 0; y < v; y++) begin
            len = (y == v - 1) ? h + extra : h;
            for (int x = 0; x < len; x++) begin
                if (n == stop_after) return;
                pos = y * h + x;
                rel = (pos >= voff) ? pos - voff : pos - voff + f;
                drive_pixel(x < 4, vs_en && (rel < 2 * h),
                            (y >= 2) && (y < 2 + va) && (x >= 6) && (x < 6 + ha));
                n++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        hs = 1'b0;
        vs = 1'b0;
        de = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tb_armed = 0;
        tb_locked = 0;
        tb_mcnt = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({h_total, v_total, h_active, v_active} !== '0) begin
            errors++;
            $display("FAIL reset_meas: got %0d/%0d/%0d/%0d, required 0/0/0/0", h_total, v_total, h_active, v_active);
        end
        checks++;
        if ({meas_valid, frame_strobe, locked, lock_lost} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got valid/strobe/locked/lost=%b, required 0000",
                     {meas_valid, frame_strobe, locked, lock_lost});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({meas_valid, frame_strobe, locked} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got valid/strobe/locked=%b, required 000", {meas_valid, frame_strobe, locked});
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_lock();
        do_reset();
        repeat (4) send_frame(HT, VT, HA, VA, 0, 0, 1'b1, -1);
        while (exp_q.size() > 0) begin
            exp_m = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL lock_strobe: got no strobe, required h=%0d v=%0d lk=%0b", exp_m.h, exp_m.v, exp_m.lk);
            end else begin
                obs_m = obs_q.pop_front();
                $display("lock strobe: h=%0d v=%0d ha=%0d va=%0d locked=%0b lost=%0b", obs_m.h, obs_m.v, obs_m.ha, obs_m.va, obs_m.lk, obs_m.ll);
                if (obs_m !== exp_m) begin
                    errors++;
                    $display("FAIL lock_strobe: got %0d/%0d/%0d/%0d lk=%0b ll=%0b, required %0d/%0d/%0d/%0d lk=%0b ll=%0b",
                             obs_m.h, obs_m.v, obs_m.ha, obs_m.va, obs_m.lk, obs_m.ll, exp_m.h, exp_m.v, exp_m.ha, exp_m.va, exp_m.lk, exp_m.ll);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL lock_extra: got %0d extra strobes, required 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (locked !== 1'b1 || meas_valid !== 1'b1) begin
            errors++;
            $display("FAIL lock_state: got locked=%b valid=%b, required 1 1", locked, meas_valid);
        end
    endtask

    task automatic test_mismatch_recover();
        lost_cnt = 0;
        send_frame(HT, VT, HA, VA, 1, 0, 1'b1, -1);
        repeat (4) send_frame(HT, VT, HA, VA, 0, 0, 1'b1, -1);
        while (exp_q.size() > 0) begin
            exp_m = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL relock_strobe: got no strobe, required h=%0d lk=%0b", exp_m.h, exp_m.lk);
            end else begin
                obs_m = obs_q.pop_front();
                $display("relock strobe: h=%0d v=%0d ha=%0d va=%0d locked=%0b lost=%0b", obs_m.h, obs_m.v, obs_m.ha, obs_m.va, obs_m.lk, obs_m.ll);
                if (obs_m !== exp_m) begin
                    errors++;
                    $display("FAIL relock_strobe: got %0d/%0d/%0d/%0d lk=%0b ll=%0b, required %0d/%0d/%0d/%0d lk=%0b ll=%0b",
                             obs_m.h, obs_m.v, obs_m.ha, obs_m.va, obs_m.lk, obs_m.ll, exp_m.h, exp_m.v, exp_m.ha, exp_m.va, exp_m.lk, exp_m.ll);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL relock_extra: got %0d extra strobes, required 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (lost_cnt != 1) begin
            errors++;
            $display("FAIL relock_lost_pulses: got %0d, required 1", lost_cnt);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL relock_state: got locked=%b, required 1", locked);
        end
    endtask

    task automatic test_timeout();
        lost_cnt = 0;
        repeat (3) send_frame(HT, VT, HA, VA, 0, 0, 1'b0, -1);
        tb_armed = 0;
        tb_locked = 0;
        tb_mcnt = 0;
        $display("timeout: lost pulses=%0d at cycle %0d, last vsync rise %0d", lost_cnt, lost_cyc, last_vrise_cyc);
        checks++;
        if (lost_cnt != 1) begin
            errors++;
            $display("FAIL timeout_lost_pulses: got %0d, required 1", lost_cnt);
        end
        checks++;
        if (lost_cyc != last_vrise_cyc + WD_LIMIT + 3) begin
            errors++;
            $display("FAIL timeout_when: got cycle %0d, required %0d", lost_cyc, last_vrise_cyc + WD_LIMIT + 3);
        end
        checks++;
        if (locked !== 1'b0 || meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got locked=%b valid=%b, required 0 0", locked, meas_valid);
        end
        checks++;
        if (h_total !== CW'(HT) || v_total !== CW'(VT) || h_active !== CW'(HA) || v_active !== CW'(VA)) begin
            errors++;
            $display("FAIL timeout_hold: got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
                     h_total, v_total, h_active, v_active, HT, VT, HA, VA);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_strobe: got %0d strobes, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        repeat (4) send_frame(HT, VT, HA, VA, 0, 0, 1'b1, -1);
        send_frame(HT, VT, HA, VA, 0, 0, 1'b1, 300);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_prelock: got locked=%b, required 1", locked);
        end
        exp_q.delete();
        obs_q.delete();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({h_total, v_total, h_active, v_active, meas_valid, frame_strobe, locked, lock_lost} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got %0d/%0d/%0d/%0d flags=%b, required all 0", h_total, v_total, h_active, v_active,
                     {meas_valid, frame_strobe, locked, lock_lost});
        end
        $display("reset mid-frame: outputs checked while rst high");
        do_reset();
        repeat (4) send_frame(HT, VT, HA, VA, 0, 0, 1'b1, -1);
        while (exp_q.size() > 0) begin
            exp_m = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL rstmid_strobe: got no strobe, required h=%0d lk=%0b", exp_m.h, exp_m.lk);
            end else begin
                obs_m = obs_q.pop_front();
                $display("post-reset strobe: h=%0d v=%0d ha=%0d va=%0d locked=%0b lost=%0b", obs_m.h, obs_m.v, obs_m.ha, obs_m.va, obs_m.lk, obs_m.ll);
                if (obs_m !== exp_m) begin
                    errors++;
                    $display("FAIL rstmid_strobe: got %0d/%0d/%0d/%0d lk=%0b ll=%0b, required %0d/%0d/%0d/%0d lk=%0b ll=%0b",
                             obs_m.h, obs_m.v, obs_m.ha, obs_m.va, obs_m.lk, obs_m.ll, exp_m.h, exp_m.v, exp_m.ha, exp_m.va, exp_m.lk, exp_m.ll);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_extra: got %0d extra strobes, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_offset();
        do_reset();
        repeat (4) send_frame(HT, VT, HA, VA, 0, 20, 1'b1, -1);
        while (exp_q.size() > 0) begin
            exp_m = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL offset_strobe: got no strobe, required v=%0d lk=%0b", exp_m.v, exp_m.lk);
            end else begin
                obs_m = obs_q.pop_front();
                $display("offset strobe: h=%0d v=%0d ha=%0d va=%0d locked=%0b lost=%0b", obs_m.h, obs_m.v, obs_m.ha, obs_m.va, obs_m.lk, obs_m.ll);
                if (obs_m !== exp_m) begin
                    errors++;
                    $display("FAIL offset_strobe: got %0d/%0d/%0d/%0d lk=%0b ll=%0b, required %0d/%0d/%0d/%0d lk=%0b ll=%0b",
                             obs_m.h, obs_m.v, obs_m.ha, obs_m.va, obs_m.lk, obs_m.ll, exp_m.h, exp_m.v, exp_m.ha, exp_m.va, exp_m.lk, exp_m.ll);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL offset_extra: got %0d extra strobes, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_other_mode();
        do_reset();
        lost_cnt = 0;
        repeat (4) send_frame(36, 18, 28, 14, 0, 0, 1'b1, -1);
        while (exp_q.size() > 0) begin
            exp_m = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL mode_strobe: got no strobe, required h=%0d v=%0d", exp_m.h, exp_m.v);
            end else begin
                obs_m = obs_q.pop_front();
                $display("other-mode strobe: h=%0d v=%0d ha=%0d va=%0d locked=%0b lost=%0b", obs_m.h, obs_m.v, obs_m.ha, obs_m.va, obs_m.lk, obs_m.ll);
                if (obs_m !== exp_m) begin
                    errors++;
                    $display("FAIL mode_strobe: got %0d/%0d/%0d/%0d lk=%0b ll=%0b, required %0d/%0d/%0d/%0d lk=%0b ll=%0b",
                             obs_m.h, obs_m.v, obs_m.ha, obs_m.va, obs_m.lk, obs_m.ll, exp_m.h, exp_m.v, exp_m.ha, exp_m.va, exp_m.lk, exp_m.ll);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL mode_extra: got %0d extra strobes, required 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (lost_cnt != 0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL mode_nolock: got lost pulses=%0d locked=%b, required 0 0", lost_cnt, locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_mismatch_recover();
        test_timeout();
        test_reset_mid();
        test_offset();
        test_other_mode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "time limit expired");
    end

endmodule
